// File: rtl/fb_pkg.sv
// Shared definitions for the frame writer: FSM states and fixed AXI4 encodings.
package fb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AW   = 2'd1,
      ST_W    = 2'd2
   } fb_state_e;

   localparam logic [2:0] AXI_SIZE_8B     = 3'd3;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam int         BEAT_BYTES_LOG2 = 3;

endpackage

// File: rtl/axi4_stream_if.sv
// 64-bit AXI4-Stream bundle carrying video words; tuser marks start of frame, tlast end of line.
interface axi4_stream_if;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic [7:0]  tstrb;
   logic        tuser;
   logic        tlast;
   logic        tvalid;
   logic        tready;

   modport master (output tdata, tkeep, tstrb, tuser, tlast, tvalid, input tready);
   modport slave  (input tdata, tkeep, tstrb, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/frame_wr_burst.sv
// Turns a line-structured video stream into AXI4 INCR write bursts with bounded outstanding
// responses, padding short lines and flagging framing or response errors.
module frame_wr_burst
   import fb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 480,
   parameter int BURST_LEN  = 16,
   parameter int MAX_OUTST  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   axi4_stream_if.slave      pkt_i,
   input  logic [ADDR_W-1:0] frame_base_i,
   output logic [ADDR_W-1:0] awaddr_o,
   output logic [7:0]        awlen_o,
   output logic [2:0]        awsize_o,
   output logic [1:0]        awburst_o,
   output logic              awvalid_o,
   input  logic              awready_i,
   output logic [63:0]       wdata_o,
   output logic [7:0]        wstrb_o,
   output logic              wlast_o,
   output logic              wvalid_o,
   input  logic              wready_i,
   input  logic [1:0]        bresp_i,
   input  logic              bvalid_i,
   output logic              bready_o,
   output logic              err_o,
   output logic              idle_o
);

   localparam int WL_W = $clog2(LINE_WORDS + 1);
   localparam int OS_W = $clog2(MAX_OUTST + 1);
   localparam logic [WL_W-1:0] LINE_WORDS_C = WL_W'(LINE_WORDS);

   fb_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [WL_W-1:0]   wl_q, wl_d;
   logic [7:0]        awlen_q, awlen_d;
   logic [7:0]        beat_q, beat_d;
   logic [OS_W-1:0]   outst_q, outst_d;
   logic              awvalid_q, awvalid_d;
   logic              pad_q, pad_d;
   logic              eol_q, eol_d;
   logic              err_q, err_d;

   logic [WL_W-1:0]   wl_head;
   logic [8:0]        head_beats;
   logic [8:0]        burst_n;
   logic [31:0]       pos;
   logic [31:0]       wl_rem;
   logic              last_beat;
   logic              in_w;
   logic              w_hs;
   logic              str_hs;
   logic              aw_hs;
   logic              b_dec;

   assign in_w      = (state_q == ST_W);
   assign last_beat = (beat_q == awlen_q);
   assign burst_n   = 9'(awlen_q) + 9'd1;
   // Words still owed to the line at the current beat, counting this one.
   assign pos       = 32'(wl_q) - 32'(beat_q);
   assign wl_rem    = 32'(wl_q) - 32'(burst_n);

   assign wvalid_o     = in_w && (pad_q || pkt_i.tvalid);
   assign pkt_i.tready = in_w && !pad_q && wready_i;
   assign wdata_o      = pkt_i.tdata;
   assign wstrb_o      = (in_w && !pad_q) ? (pkt_i.tkeep & pkt_i.tstrb) : 8'h00;
   assign wlast_o      = in_w && last_beat;

   assign w_hs   = wvalid_o && wready_i;
   assign str_hs = pkt_i.tready && pkt_i.tvalid;
   assign aw_hs  = awvalid_q && awready_i;
   assign b_dec  = bvalid_i && (outst_q != '0);

   assign awaddr_o  = addr_q;
   assign awlen_o   = awlen_q;
   assign awsize_o  = AXI_SIZE_8B;
   assign awburst_o = AXI_BURST_INCR;
   assign awvalid_o = awvalid_q;
   assign bready_o  = 1'b1;
   assign err_o     = err_q;
   assign idle_o    = (state_q == ST_IDLE) && (outst_q == '0);

   always_comb begin
      wl_head    = pkt_i.tuser ? LINE_WORDS_C : wl_q;
      head_beats = (32'(wl_head) < 32'(BURST_LEN)) ? 9'(wl_head) : 9'(BURST_LEN);

      state_d   = state_q;
      addr_d    = addr_q;
      wl_d      = wl_q;
      awlen_d   = awlen_q;
      beat_d    = beat_q;
      awvalid_d = awvalid_q;
      pad_d     = pad_q;
      eol_d     = eol_q;
      err_d     = err_q;
      outst_d   = outst_q;

      case (state_q)
         ST_IDLE: begin
            if (pkt_i.tvalid && (outst_q < OS_W'(MAX_OUTST))) begin
               if (pkt_i.tuser) begin
                  addr_d = frame_base_i;
                  wl_d   = LINE_WORDS_C;
               end
               awlen_d   = 8'(head_beats - 9'd1);
               awvalid_d = 1'b1;
               beat_d    = 8'd0;
               state_d   = ST_AW;
            end
         end
         ST_AW: begin
            if (awready_i) begin
               awvalid_d = 1'b0;
               state_d   = ST_W;
            end
         end
         ST_W: begin
            if (str_hs) begin
               if ((beat_q != 8'd0) && pkt_i.tuser) begin
                  err_d = 1'b1;
               end
               if (pkt_i.tlast && (pos > 32'd1)) begin
                  err_d = 1'b1;
                  eol_d = 1'b1;
                  pad_d = !last_beat;
               end
               // A word that must end the line but lacks tlast still closes it.
               if (!pkt_i.tlast && (pos == 32'd1)) begin
                  err_d = 1'b1;
               end
            end
            if (w_hs) begin
               beat_d = beat_q + 8'd1;
               if (last_beat) begin
                  addr_d  = addr_q + (ADDR_W'(burst_n) << BEAT_BYTES_LOG2);
                  wl_d    = (eol_d || (wl_rem == 32'd0)) ? LINE_WORDS_C : WL_W'(wl_rem);
                  beat_d  = 8'd0;
                  pad_d   = 1'b0;
                  eol_d   = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (bvalid_i && (bresp_i != AXI_RESP_OKAY)) begin
         err_d = 1'b1;
      end

      if (aw_hs && !b_dec) begin
         outst_d = outst_q + OS_W'(1);
      end else if (!aw_hs && b_dec) begin
         outst_d = outst_q - OS_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wl_q      <= LINE_WORDS_C;
         awlen_q   <= 8'd0;
         beat_q    <= 8'd0;
         outst_q   <= '0;
         awvalid_q <= 1'b0;
         pad_q     <= 1'b0;
         eol_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wl_q      <= wl_d;
         awlen_q   <= awlen_d;
         beat_q    <= beat_d;
         outst_q   <= outst_d;
         awvalid_q <= awvalid_d;
         pad_q     <= pad_d;
         eol_q     <= eol_d;
         err_q     <= err_d;
      end
   end

endmodule
